// File: rtl/video_pkg.sv
// video_pkg: shared encodings, bar colours and sizing helper for the video pattern generator.
package video_pkg;
  typedef enum logic [1:0] {MODE_SOLID, MODE_GRADIENT, MODE_BARS, MODE_CHECKER} mode_e;
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK} state_e;
  localparam logic [23:0] C_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] C_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] C_CYAN    = 24'h00FFFF;
  localparam logic [23:0] C_GREEN   = 24'h00FF00;
  localparam logic [23:0] C_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] C_RED     = 24'hFF0000;
  localparam logic [23:0] C_BLUE    = 24'h0000FF;
  localparam logic [23:0] C_BLACK   = 24'h000000;
  function automatic logic [23:0] bar_color(input logic [2:0] b);
    case (b)
      3'd0: return C_WHITE;
      3'd1: return C_YELLOW;
      3'd2: return C_CYAN;
      3'd3: return C_GREEN;
      3'd4: return C_MAGENTA;
      3'd5: return C_RED;
      3'd6: return C_BLUE;
      default: return C_BLACK;
    endcase
  endfunction
  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/video_pattern_pixel.sv
// video_pattern_pixel: combinational pixel value for a given mode, position and solid colour.
module video_pattern_pixel
  import video_pkg::*;
#(
  parameter int DW = 24,
  parameter int W  = 640,
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  mode_e          mode,
  input  logic [XW-1:0]  x,
  input  logic [YW-1:0]  y,
  input  logic [DW-1:0]  solid_color,
  output logic [DW-1:0]  pixel
);
  logic [7:0] x8, y8;
  logic [2:0] bar;
  assign x8 = 8'(x);
  assign y8 = 8'(y);
  assign bar = 3'((32'(x) << 3) / 32'(W));
  always_comb pixel = mode == MODE_SOLID    ? solid_color :
                      mode == MODE_GRADIENT ? DW'({x8, y8, 8'(x8 + y8)}) :
                      mode == MODE_BARS     ? DW'(bar_color(bar)) :
                      DW'((x8[3] ^ y8[3]) ? C_WHITE : C_BLACK);
endmodule

// File: rtl/axis_video_pattern_gen.sv
// axis_video_pattern_gen: AXI4-Stream test pattern source with line blanking and frame counting.
module axis_video_pattern_gen
  import video_pkg::*;
#(
  parameter int IMAGE_WIDTH      = 640,
  parameter int IMAGE_HEIGHT     = 480,
  parameter int AXIS_TDATA_WIDTH = 24,
  parameter int H_BLANK          = 0
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        start,
  input  logic                        continuous,
  input  logic [1:0]                  mode,
  input  logic [AXIS_TDATA_WIDTH-1:0] solid_color,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tuser,
  output logic                        busy,
  output logic                        frame_done,
  output logic [15:0]                 frame_count
);
  localparam int XW = cnt_w(IMAGE_WIDTH);
  localparam int YW = cnt_w(IMAGE_HEIGHT);
  localparam int BW = cnt_w(H_BLANK);
  localparam int DW = AXIS_TDATA_WIDTH;
  state_e        state, state_n;
  logic [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  mode_e         mode_r, mode_n;
  logic [DW-1:0] color_r, color_n, pix;
  logic [BW-1:0] blank, blank_n;
  logic          hs, line_end, frame_end;
  assign hs            = state == S_ACTIVE && m_axis_tready;
  assign line_end      = hs && x == XW'(IMAGE_WIDTH - 1);
  assign frame_end     = line_end && y == YW'(IMAGE_HEIGHT - 1);
  assign m_axis_tvalid = state == S_ACTIVE;
  assign busy          = state != S_IDLE;
  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    mode_n  = mode_r;
    color_n = color_r;
    blank_n = blank;
    case (state)
      S_IDLE: if (start) begin
        state_n = S_ACTIVE;
        x_n     = '0;
        y_n     = '0;
        mode_n  = mode_e'(mode);
        color_n = solid_color;
      end
      S_ACTIVE: if (frame_end) begin
        x_n     = '0;
        y_n     = '0;
        state_n = continuous ? S_ACTIVE : S_IDLE;
        mode_n  = continuous ? mode_e'(mode) : mode_r;
        color_n = continuous ? solid_color : color_r;
      end else if (line_end) begin
        x_n     = '0;
        y_n     = y + 1'b1;
        blank_n = '0;
        state_n = H_BLANK > 0 ? S_HBLANK : S_ACTIVE;
      end else if (hs) x_n = x + 1'b1;
      S_HBLANK: begin
        blank_n = blank + 1'b1;
        state_n = blank == BW'(H_BLANK - 1) ? S_ACTIVE : S_HBLANK;
      end
      default: state_n = S_IDLE;
    endcase
  end
  // Pixel is computed from the next position so registered outputs line up with tvalid.
  video_pattern_pixel #(.DW(DW), .W(IMAGE_WIDTH), .XW(XW), .YW(YW)) u_pixel (
    .mode        (mode_n),
    .x           (x_n),
    .y           (y_n),
    .solid_color (color_n),
    .pixel       (pix)
  );
  always_ff @(posedge aclk) begin
    if (areset) begin
      state        <= S_IDLE;
      x            <= '0;
      y            <= '0;
      mode_r       <= MODE_SOLID;
      color_r      <= '0;
      blank        <= '0;
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
      m_axis_tuser <= 1'b0;
      frame_done   <= 1'b0;
      frame_count  <= '0;
    end else begin
      state        <= state_n;
      x            <= x_n;
      y            <= y_n;
      mode_r       <= mode_n;
      color_r      <= color_n;
      blank        <= blank_n;
      m_axis_tdata <= state_n == S_IDLE ? '0 : pix;
      m_axis_tlast <= state_n != S_IDLE && x_n == XW'(IMAGE_WIDTH - 1);
      m_axis_tuser <= state_n != S_IDLE && x_n == '0 && y_n == '0;
      frame_done   <= frame_end;
      frame_count  <= frame_count + 16'(frame_end);
    end
  end
endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// tb_axis_video_pattern_gen: randomized self-checking bench against a behavioural pattern model.
module tb_axis_video_pattern_gen;
  localparam int W = 320, H = 16, WB = 24, HB_H = 6, HB = 4;
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  logic clk = 0, areset = 1, start = 0, continuous = 0, tready = 0;
  logic [1:0] mode = 0;
  logic [23:0] solid_color = 0, tdata;
  logic tvalid, tlast, tuser, busy, frame_done;
  logic [15:0] frame_count;
  logic start_b = 0, continuous_b = 0, tready_b = 0;
  logic [23:0] tdata_b;
  logic tvalid_b, tlast_b, tuser_b, busy_b, frame_done_b;
  logic [15:0] frame_count_b;
  int checks = 0, errors = 0, fc_model = 0;
  int n_beats, n_bad, n_tuser_bad, n_tlast_bad, n_tlasts, n_done, n_unstable, n_cycles;
  logic [23:0] frame_mem [W*H];

  axis_video_pattern_gen #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .AXIS_TDATA_WIDTH(24), .H_BLANK(0)) dut (
    .aclk(clk), .areset(areset), .start(start), .continuous(continuous), .mode(mode),
    .solid_color(solid_color), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .m_axis_tuser(tuser), .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count));

  axis_video_pattern_gen #(.IMAGE_WIDTH(WB), .IMAGE_HEIGHT(HB_H), .AXIS_TDATA_WIDTH(24), .H_BLANK(HB)) dut_b (
    .aclk(clk), .areset(areset), .start(start_b), .continuous(continuous_b), .mode(mode),
    .solid_color(solid_color), .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(tready_b),
    .m_axis_tlast(tlast_b), .m_axis_tuser(tuser_b), .busy(busy_b), .frame_done(frame_done_b),
    .frame_count(frame_count_b));

  always #5 clk = ~clk;

  function automatic logic [23:0] golden(int m, int px, int py, logic [23:0] c, int w);
    case (m)
      0: return c;
      1: return {8'(px % 256), 8'(py % 256), 8'((px + py) % 256)};
      2: return BARS[(px * 8) / w];
      default: return (((px / 8) % 2) != ((py / 8) % 2)) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  // Receives one frame from the main DUT, tallying deviations from the model.
  task automatic collect(input int m, input logic [23:0] c, input int pct, input bit disturb);
    int ex = 0, ey = 0, limit = W * H * 4 + 200;
    bit stall = 0;
    logic [23:0] held = 0;
    n_beats = 0; n_bad = 0; n_tuser_bad = 0; n_tlast_bad = 0; n_tlasts = 0;
    n_done = 0; n_unstable = 0; n_cycles = 0;
    while (n_cycles < limit) begin
      @(negedge clk);
      start = 0;
      if (disturb && n_cycles == 100) begin
        start = 1;
        mode = ~mode;
        solid_color = ~c;
      end
      n_done += int'(frame_done);
      if (n_beats == W * H) break;
      n_cycles++;
      tready = ($urandom_range(99) < 32'(pct));
      if (stall && (!tvalid || tdata !== held)) n_unstable++;
      if (tvalid) begin
        if (tdata !== golden(m, ex, ey, c, W)) n_bad++;
        if (tuser !== (ex == 0 && ey == 0)) n_tuser_bad++;
        if (tlast !== (ex == W - 1)) n_tlast_bad++;
      end
      stall = tvalid && !tready;
      held = tdata;
      if (tvalid && tready) begin
        frame_mem[ey * W + ex] = tdata;
        n_tlasts += int'(tlast);
        n_beats++;
        ey = (ex == W - 1) ? ey + 1 : ey;
        ex = (ex == W - 1) ? 0 : ex + 1;
      end
    end
    start = 0;
  endtask

  task automatic launch(input int m, input logic [23:0] c);
    @(negedge clk);
    mode = 2'(m);
    solid_color = c;
    start = 1;
  endtask

  task automatic test_reset;
    areset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", tvalid); end
    checks++; if (tdata !== 24'h0) begin errors++; $display("FAIL reset_tdata: got %h expected 000000", tdata); end
    checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b expected 0", tlast); end
    checks++; if (tuser !== 1'b0) begin errors++; $display("FAIL reset_tuser: got %b expected 0", tuser); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame_count: got %0d expected 0", frame_count); end
    checks++; if (tvalid_b !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_b: got valid %b busy %b expected 0 0", tvalid_b, busy_b); end
    areset = 0;
    fc_model = 0;
  endtask

  task automatic test_reset_midframe;
    int b = 0, bad = 0;
    bit found = 0;
    launch(1, 24'h0);
    tready = 1;
    for (int i = 0; i < W * H * 2 && !found; i++) begin
      @(negedge clk);
      start = 0;
      if (tvalid && tdata !== golden(1, b % W, b / W, 24'h0, W)) bad++;
      if (tvalid && b == 10 * W + 100) begin
        found = 1;
        areset = 1;
      end else if (tvalid) b++;
    end
    checks++; if (!found || bad != 0) begin errors++; $display("FAIL midframe_reach: got found %0d bad %0d expected 1 0", found, bad); end
    @(negedge clk);
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL midframe_tvalid: got %b expected 0", tvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midframe_busy: got %b expected 0", busy); end
    checks++; if (frame_count !== 16'(fc_model)) begin errors++; $display("FAIL midframe_count: got %0d expected %0d", frame_count, fc_model); end
    areset = 0;
    @(negedge clk);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL midframe_done: got %b expected 0", frame_done); end
    launch(3, 24'h0);
    collect(3, 24'h0, 100, 0);
    fc_model++;
    checks++; if (n_tuser_bad != 0 || n_bad != 0) begin errors++; $display("FAIL restart_frame: got tuser_bad %0d data_bad %0d expected 0 0", n_tuser_bad, n_bad); end
    checks++; if (frame_count !== 16'(fc_model)) begin errors++; $display("FAIL restart_count: got %0d expected %0d", frame_count, fc_model); end
  endtask

  task automatic test_solid_throughput;
    launch(0, 24'h123456);
    collect(0, 24'h123456, 100, 0);
    fc_model++;
    checks++; if (n_beats != W * H) begin errors++; $display("FAIL solid_beats: got %0d expected %0d", n_beats, W * H); end
    checks++; if (n_cycles != W * H) begin errors++; $display("FAIL solid_cycles: got %0d expected %0d", n_cycles, W * H); end
    checks++; if (n_bad != 0) begin errors++; $display("FAIL solid_data: got %0d bad expected 0", n_bad); end
    checks++; if (n_tuser_bad != 0) begin errors++; $display("FAIL solid_tuser: got %0d bad expected 0", n_tuser_bad); end
    checks++; if (n_tlast_bad != 0 || n_tlasts != H) begin errors++; $display("FAIL solid_tlast: got bad %0d count %0d expected 0 %0d", n_tlast_bad, n_tlasts, H); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL solid_done: got %0d expected 1", n_done); end
    checks++; if (frame_count !== 16'(fc_model)) begin errors++; $display("FAIL solid_count: got %0d expected %0d", frame_count, fc_model); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL solid_idle: got busy %b expected 0", busy); end
  endtask

  task automatic test_bars;
    launch(2, 24'h0);
    collect(2, 24'h0, 100, 0);
    fc_model++;
    checks++; if (n_bad != 0 || n_beats != W * H) begin errors++; $display("FAIL bars_frame: got bad %0d beats %0d expected 0 %0d", n_bad, n_beats, W * H); end
    checks++; if (frame_mem[39] !== 24'hFFFFFF) begin errors++; $display("FAIL bars_x39: got %h expected FFFFFF", frame_mem[39]); end
    checks++; if (frame_mem[40] !== 24'hFFFF00) begin errors++; $display("FAIL bars_x40: got %h expected FFFF00", frame_mem[40]); end
    checks++; if (frame_mem[279] !== 24'h0000FF) begin errors++; $display("FAIL bars_x279: got %h expected 0000FF", frame_mem[279]); end
    checks++; if (frame_mem[W + 280] !== 24'h000000) begin errors++; $display("FAIL bars_x280: got %h expected 000000", frame_mem[W + 280]); end
  endtask

  task automatic test_checker;
    launch(3, 24'h0);
    collect(3, 24'h0, 100, 0);
    fc_model++;
    checks++; if (n_bad != 0) begin errors++; $display("FAIL checker_frame: got %0d bad expected 0", n_bad); end
    checks++; if (frame_mem[8] !== 24'hFFFFFF) begin errors++; $display("FAIL checker_8_0: got %h expected FFFFFF", frame_mem[8]); end
    checks++; if (frame_mem[8 * W + 8] !== 24'h000000) begin errors++; $display("FAIL checker_8_8: got %h expected 000000", frame_mem[8 * W + 8]); end
    checks++; if (frame_mem[8 * W] !== 24'hFFFFFF) begin errors++; $display("FAIL checker_0_8: got %h expected FFFFFF", frame_mem[8 * W]); end
  endtask

  task automatic test_gradient_backpressure;
    launch(1, 24'h0);
    collect(1, 24'h0, 50, 0);
    fc_model++;
    checks++; if (n_beats != W * H || n_bad != 0) begin errors++; $display("FAIL grad_frame: got beats %0d bad %0d expected %0d 0", n_beats, n_bad, W * H); end
    checks++; if (n_unstable != 0) begin errors++; $display("FAIL grad_stable: got %0d unstable expected 0", n_unstable); end
    checks++; if (frame_mem[10 * W + 300] !== 24'h2C0A36) begin errors++; $display("FAIL grad_300_10: got %h expected 2C0A36", frame_mem[10 * W + 300]); end
    checks++; if (n_done != 1 || frame_count !== 16'(fc_model)) begin errors++; $display("FAIL grad_done: got done %0d count %0d expected 1 %0d", n_done, frame_count, fc_model); end
  endtask

  task automatic test_busy_ignore;
    logic [23:0] c = 24'($urandom);
    launch(0, c);
    collect(0, c, 80, 1);
    fc_model++;
    checks++; if (n_bad != 0 || n_beats != W * H) begin errors++; $display("FAIL latch_frame: got bad %0d beats %0d expected 0 %0d", n_bad, n_beats, W * H); end
    checks++; if (n_unstable != 0) begin errors++; $display("FAIL latch_stable: got %0d unstable expected 0", n_unstable); end
    checks++; if (busy !== 1'b0 || frame_count !== 16'(fc_model)) begin errors++; $display("FAIL latch_restart: got busy %b count %0d expected 0 %0d", busy, frame_count, fc_model); end
  endtask

  task automatic test_blanking_continuous;
    int total = WB * HB_H, beats = 0, ex = 0, ey = 0, gap = 0, exp_gap = 0;
    int bad = 0, bad_gap = 0, gap_checks = 0, idle_bad = 0, done = 0;
    bit waiting = 0;
    @(negedge clk);
    mode = 2'd1;
    continuous_b = 1;
    start_b = 1;
    for (int i = 0; i < total * 3 * 4 + 400; i++) begin
      @(negedge clk);
      start_b = 0;
      if (beats >= 2 * total + total / 2) continuous_b = 0;
      done += int'(frame_done_b);
      if (beats == 3 * total) break;
      tready_b = ($urandom_range(99) < 70);
      if (tvalid_b) begin
        if (tdata_b !== golden(1, ex, ey, 24'h0, WB)) bad++;
        if (waiting) begin
          gap_checks++;
          if (gap != exp_gap) bad_gap++;
          waiting = 0;
        end
      end else if (waiting) gap++;
      else idle_bad++;
      if (tvalid_b && tready_b) begin
        beats++;
        if (ex == WB - 1) begin
          waiting = 1;
          gap = 0;
          exp_gap = (ey == HB_H - 1) ? 0 : HB;
        end
        ey = (ex == WB - 1) ? (ey + 1) % HB_H : ey;
        ex = (ex == WB - 1) ? 0 : ex + 1;
      end
    end
    checks++; if (beats != 3 * total || bad != 0) begin errors++; $display("FAIL blank_frames: got beats %0d bad %0d expected %0d 0", beats, bad, 3 * total); end
    checks++; if (bad_gap != 0 || gap_checks != 3 * HB_H - 1) begin errors++; $display("FAIL blank_gaps: got bad %0d measured %0d expected 0 %0d", bad_gap, gap_checks, 3 * HB_H - 1); end
    checks++; if (idle_bad != 0) begin errors++; $display("FAIL blank_unexpected_idle: got %0d expected 0", idle_bad); end
    checks++; if (done != 3 || frame_count_b !== 16'd3) begin errors++; $display("FAIL blank_count: got done %0d count %0d expected 3 3", done, frame_count_b); end
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL blank_idle: got busy %b expected 0", busy_b); end
  endtask

  initial begin
    test_reset;
    test_reset_midframe;
    test_solid_throughput;
    test_bars;
    test_checker;
    test_gradient_backpressure;
    test_busy_ignore;
    test_blanking_continuous;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
